// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver feeding a show-ahead byte FIFO with sticky error flags.
// Define UART_RX_MONITOR_PARITY_EN for 8E1 frames and a parity_error output.
module uart_rx_monitor #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_error,
  output logic                          overflow,
`ifdef UART_RX_MONITOR_PARITY_EN
  output logic                          parity_error,
`endif
  input  logic                          clear_errors,
  output logic [15:0]                   byte_count
);
  localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic framing_q, framing_d, ovf_q, ovf_d;
  logic push, set_fe, bit_end, rx_s, pop, full, wr;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;
  logic [15:0] byte_count_q;
  logic [7:0] mem_q [FIFO_DEPTH];
`ifdef UART_RX_MONITOR_PARITY_EN
  logic par_bad_q, par_bad_d, perr_q, perr_d, set_pe;
`endif

  assign rx_s = sync_q[1];
  assign bit_end = cnt_q == CW'(CPB - 1);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    push = 1'b0;
    set_fe = 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
    par_bad_d = par_bad_q;
    set_pe = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[7:1]};
        idx_d = idx_q + 1'b1;
`ifdef UART_RX_MONITOR_PARITY_EN
        state_d = idx_q == 3'd7 ? PARITY : DATA;
`else
        state_d = idx_q == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_RX_MONITOR_PARITY_EN
      PARITY: if (bit_end) begin
        cnt_d = '0;
        par_bad_d = ^{shift_q, rx_s};
        set_pe = par_bad_d;
        state_d = STOP;
      end
`endif
      STOP: if (bit_end) begin
        cnt_d = '0;
`ifdef UART_RX_MONITOR_PARITY_EN
        push = rx_s & ~par_bad_q;
`else
        push = rx_s;
`endif
        set_fe = ~rx_s;
        state_d = rx_s ? IDLE : BREAK_WAIT;
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : BREAK_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full FIFO survives only when the head is popped in the same cycle.
  assign pop = (count_q != '0) & rx_ready;
  assign full = count_q == (AW+1)'(FIFO_DEPTH);
  assign wr = push & (~full | pop);
  assign framing_d = set_fe | (framing_q & ~clear_errors);
  assign ovf_d = (push & full & ~pop) | (ovf_q & ~clear_errors);
`ifdef UART_RX_MONITOR_PARITY_EN
  assign perr_d = set_pe | (perr_q & ~clear_errors);
  assign parity_error = perr_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      framing_q <= 1'b0;
      ovf_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      byte_count_q <= '0;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], uart_rx};
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      framing_q <= framing_d;
      ovf_q <= ovf_d;
      wptr_q <= wptr_q + AW'(wr);
      rptr_q <= rptr_q + AW'(pop);
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(pop);
      byte_count_q <= byte_count_q + 16'(wr);
`ifdef UART_RX_MONITOR_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q <= perr_d;
`endif
    end
  end

  always_ff @(posedge clock) if (wr) mem_q[wptr_q] <= shift_q;

  assign rx_valid = count_q != '0;
  assign rx_data = rx_valid ? mem_q[rptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign framing_error = framing_q;
  assign overflow = ovf_q;
  assign byte_count = byte_count_q;
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed frames with a byte scoreboard drained by an independent pop monitor.
module tb_uart_rx_monitor;
  logic clock, reset, uart_rx, rx_ready, clear_errors;
  logic [7:0] rx_data;
  logic rx_valid, framing_error, overflow;
  logic [2:0] fifo_count;
  logic [15:0] byte_count;
  logic [7:0] sb [$];
  logic [15:0] bc;
  int errors = 0, checks = 0;

  uart_rx_monitor #(.CLOCK_FREQUENCY(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .uart_rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_count(fifo_count), .framing_error(framing_error),
    .overflow(overflow), .clear_errors(clear_errors), .byte_count(byte_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && rx_valid && rx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %02h, expected no byte", rx_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %02h expected %02h", rx_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_wait();
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    uart_rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      bit_wait();
    end
    if (stop_low > 0) begin
      uart_rx = 1'b0;
      repeat (stop_low) bit_wait();
    end
    uart_rx = 1'b1;
    bit_wait();
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 60 && fifo_count != 0; i++) begin
      @(posedge clock);
      #1;
    end
    rx_ready = 1'b0;
    @(negedge clock);
    chk("drain_count", fifo_count, 0);
    chk("drain_valid", rx_valid, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(posedge clock);
    #1;
    clear_errors = 1'b0;
  endtask

  initial begin
    reset = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0; clear_errors = 1'b0; bc = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bc", byte_count, 0);
    @(posedge clock);
    #1;
    // Single byte: push lands on the edge 98 cycles after the start bit is driven.
    sb.push_back(8'h55);
    fork send_frame(8'h55, 0); join_none
    repeat (97) @(posedge clock);
    #5 chk("lat_before", rx_valid, 0);
    @(posedge clock);
    #5;
    chk("lat_valid", rx_valid, 1);
    chk("lat_data", rx_data, 8'h55);
    chk("lat_count", fifo_count, 1);
    chk("lat_bc", byte_count, 1);
    chk("lat_fe", framing_error, 0);
    chk("lat_ovf", overflow, 0);
    bc = 1;
    repeat (3) @(posedge clock);
    #1 drain();
    @(posedge clock);
    #1;
    // Back-to-back "OK\n"
    sb.push_back(8'h4F); sb.push_back(8'h4B); sb.push_back(8'h0A);
    send_frame(8'h4F, 0); send_frame(8'h4B, 0); send_frame(8'h0A, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("ok_count", fifo_count, 3);
    chk("ok_head", rx_data, 8'h4F);
    bc += 3;
    chk("ok_bc", byte_count, bc);
    @(posedge clock);
    #1 drain();
    @(posedge clock);
    #1;
    // Short glitch
    uart_rx = 1'b0;
    repeat (3) @(posedge clock);
    #1 uart_rx = 1'b1;
    repeat (30) @(posedge clock);
    @(negedge clock);
    chk("gl_count", fifo_count, 0);
    chk("gl_bc", byte_count, bc);
    chk("gl_fe", framing_error, 0);
    chk("gl_ovf", overflow, 0);
    @(posedge clock);
    #1;
    // Framing error then recovery
    send_frame(8'hA3, 2);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("fe_set", framing_error, 1);
    chk("fe_count", fifo_count, 0);
    chk("fe_bc", byte_count, bc);
    @(posedge clock);
    #1;
    sb.push_back(8'h11);
    send_frame(8'h11, 0);
    @(negedge clock);
    chk("fe_next_count", fifo_count, 1);
    chk("fe_next_data", rx_data, 8'h11);
    chk("fe_sticky", framing_error, 1);
    bc += 1;
    @(posedge clock);
    #1 pulse_clear();
    @(negedge clock);
    chk("fe_clear", framing_error, 0);
    @(posedge clock);
    #1 drain();
    @(posedge clock);
    #1;
    // Overflow: fifth byte dropped
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back(8'(i));
      send_frame(8'(i), 0);
    end
    @(negedge clock);
    bc += 4;
    chk("ovf_count", fifo_count, 4);
    chk("ovf_set", overflow, 1);
    chk("ovf_bc", byte_count, bc);
    @(posedge clock);
    #1 drain();
    pulse_clear();
    @(negedge clock);
    chk("ovf_clear", overflow, 0);
    @(posedge clock);
    #1;
    // Pop coinciding with the fifth push keeps it
    for (int i = 1; i <= 5; i++) sb.push_back(8'h10 + 8'(i));
    for (int i = 1; i <= 4; i++) send_frame(8'h10 + 8'(i), 0);
    fork send_frame(8'h15, 0); join_none
    repeat (97) @(posedge clock);
    #1 rx_ready = 1'b1;
    @(posedge clock);
    #1 rx_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    bc += 5;
    chk("pp_count", fifo_count, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_bc", byte_count, bc);
    @(posedge clock);
    #1 drain();
    @(posedge clock);
    #1;
    // Reset mid-frame with a queued byte and a set flag
    send_frame(8'h77, 0);
    send_frame(8'hA3, 1);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("pre_rst_count", fifo_count, 1);
    chk("pre_rst_fe", framing_error, 1);
    @(posedge clock);
    #1;
    fork send_frame(8'hFF, 0); join_none
    repeat (40) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("mr_data", rx_data, 0);
    chk("mr_valid", rx_valid, 0);
    chk("mr_count", fifo_count, 0);
    chk("mr_fe", framing_error, 0);
    chk("mr_ovf", overflow, 0);
    chk("mr_bc", byte_count, 0);
    repeat (70) @(posedge clock);
    #1;
    chk("mr_no_byte", fifo_count, 0);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 0);
    @(negedge clock);
    chk("mr_next_data", rx_data, 8'h3C);
    chk("mr_next_bc", byte_count, 1);
    @(posedge clock);
    #1 drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
